// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART byte receiver.
//   rx_state_e  - receiver FSM state
//   DATA_BITS   - payload bits per frame
//   IDLE_BITS   - bit times of high line before the line is declared idle
//   majority3   - 2-of-3 vote used by the input noise filter
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned IDLE_BITS = 10;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running divider producing a one-clk sample tick every DIV clocks.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - high for one clk when the divider reaches DIV-1
module baud_tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 LSB-first UART receiver feeding the LCD controller.
//   clk             - system clock
//   rst_n           - asynchronous active-low reset
//   RxD             - asynchronous serial input, idle high
//   RxD_data        - last correctly framed byte, held until the next one
//   RxD_data_ready  - one-clk strobe when RxD_data updates
//   RxD_idle        - line has been high for at least IDLE_BITS bit times
//   RxD_endofpacket - one-clk strobe when RxD_idle rises after at least one byte
//   framing_error   - one-clk strobe when the stop bit is sampled low
module uart_byte_receiver
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_idle,
    output logic       RxD_endofpacket,
    output logic       framing_error
);

    localparam int unsigned DIV     = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned SampW   = $clog2(OVERSAMPLE);
    localparam int unsigned BitW    = $clog2(DATA_BITS);
    localparam int unsigned IdleMax = IDLE_BITS * OVERSAMPLE;
    localparam int unsigned IdleW   = $clog2(IdleMax + 1);

    localparam logic [SampW-1:0] HalfLast = SampW'(OVERSAMPLE / 2 - 1);
    localparam logic [SampW-1:0] FullLast = SampW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);
    localparam logic [IdleW-1:0] IdleSat  = IdleW'(IdleMax);
    localparam logic [IdleW-1:0] IdlePre  = IdleW'(IdleMax - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_byte_receiver: CLK_FREQ/(BAUD*OVERSAMPLE) must be >= 2");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_os_check
        $error("uart_byte_receiver: OVERSAMPLE must be a power of two >= 4");
    end

    logic tick;

    baud_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    logic                 rxd_meta_q, rxd_sync_q;
    logic [2:0]           hist_q, hist_d;
    logic                 filtered;
    rx_state_e            state_q, state_d;
    logic [SampW-1:0]     samp_cnt_q, samp_cnt_d;
    logic [BitW-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;
    logic                 eop_q, eop_d;
    logic                 got_byte_q, got_byte_d;
    logic [IdleW-1:0]     idle_cnt_q, idle_cnt_d;

    always_comb begin
        filtered   = majority3(hist_q);
        hist_d     = hist_q;
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        ferr_d     = 1'b0;
        eop_d      = 1'b0;
        idle_cnt_d = idle_cnt_q;

        if (tick) begin
            hist_d = {hist_q[1:0], rxd_sync_q};
            unique case (state_q)
                StIdle: begin
                    if (!filtered) begin
                        state_d    = StStart;
                        samp_cnt_d = '0;
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q != IdleSat) begin
                        idle_cnt_d = idle_cnt_q + IdleW'(1);
                        // Rising edge of RxD_idle happens on this increment.
                        eop_d      = (idle_cnt_q == IdlePre) && got_byte_q;
                    end
                end
                StStart: begin
                    if (filtered) begin
                        state_d = StIdle;  // false start, no flags
                    end else if (samp_cnt_q == HalfLast) begin
                        state_d    = StData;
                        samp_cnt_d = '0;
                        bit_idx_d  = '0;
                    end else begin
                        samp_cnt_d = samp_cnt_q + SampW'(1);
                    end
                end
                StData: begin
                    if (samp_cnt_q == FullLast) begin
                        samp_cnt_d = '0;
                        shift_d    = {filtered, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == LastBit) begin
                            state_d = StStop;
                        end else begin
                            bit_idx_d = bit_idx_q + BitW'(1);
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + SampW'(1);
                    end
                end
                StStop: begin
                    if (samp_cnt_q == FullLast) begin
                        samp_cnt_d = '0;
                        if (filtered) begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = StBreak;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + SampW'(1);
                    end
                end
                StBreak: begin
                    // Held-low line must return high before a new start is armed.
                    if (filtered) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (eop_d) begin
            got_byte_d = 1'b0;
        end else if (ready_d) begin
            got_byte_d = 1'b1;
        end else begin
            got_byte_d = got_byte_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            hist_q     <= 3'b111;
            state_q    <= StIdle;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
            eop_q      <= 1'b0;
            got_byte_q <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            rxd_meta_q <= RxD;
            rxd_sync_q <= rxd_meta_q;
            hist_q     <= hist_d;
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
            eop_q      <= eop_d;
            got_byte_q <= got_byte_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign RxD_data        = data_q;
    assign RxD_data_ready  = ready_q;
    assign framing_error   = ferr_q;
    assign RxD_endofpacket = eop_q;
    assign RxD_idle        = (idle_cnt_q == IdleSat);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver: directed self-checking bench for uart_byte_receiver.
// 1.8432 MHz clock, 115200 baud, 8x oversampling: 16 clk per bit.
module tb_uart_byte_receiver;

    localparam int ClkPerBit = 16;

    logic       clk;
    logic       rst_n;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_idle;
    logic       RxD_endofpacket;
    logic       framing_error;

    uart_byte_receiver #(
        .CLK_FREQ  (1_843_200),
        .BAUD      (115200),
        .OVERSAMPLE(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RxD            (RxD),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .RxD_idle       (RxD_idle),
        .RxD_endofpacket(RxD_endofpacket),
        .framing_error  (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: counts strobes, logs bytes, flags protocol violations.
    int         n_ready = 0;
    int         n_ferr  = 0;
    int         n_eop   = 0;
    int         n_viol  = 0;
    logic [7:0] rx_q[$];
    logic       prev_ready = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic       prev_eop   = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (RxD_data_ready) begin
                n_ready++;
                rx_q.push_back(RxD_data);
            end
            if (framing_error)   n_ferr++;
            if (RxD_endofpacket) n_eop++;
            if ((RxD_data_ready && prev_ready) || (framing_error && prev_ferr) ||
                (RxD_endofpacket && prev_eop) || (RxD_data_ready && framing_error)) begin
                n_viol++;
            end
            prev_ready = RxD_data_ready;
            prev_ferr  = framing_error;
            prev_eop   = RxD_endofpacket;
        end else begin
            prev_ready = 1'b0;
            prev_ferr  = 1'b0;
            prev_eop   = 1'b0;
        end
    end

    // All drive tasks start and end on a falling clock edge.
    task automatic drive_bit(input logic b, input bit glitch);
        RxD = b;
        repeat (ClkPerBit / 2) @(negedge clk);
        if (glitch) begin
            RxD = ~b;
            repeat (2) @(negedge clk);
            RxD = b;
            repeat (ClkPerBit / 2 - 2) @(negedge clk);
        end else begin
            repeat (ClkPerBit / 2) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_bit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i], i == glitch_bit);
        drive_bit(stop, 1'b0);
    endtask

    task automatic hold(input logic b, input int bits);
        RxD = b;
        repeat (bits * ClkPerBit) @(negedge clk);
    endtask

    int r0, f0, e0, q0;

    initial begin
        rst_n = 1'b0;
        RxD   = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_data",  {24'd0, RxD_data}, 32'h00);
        check_eq("rst_ready", {31'd0, RxD_data_ready}, 32'd0);
        check_eq("rst_ferr",  {31'd0, framing_error}, 32'd0);
        check_eq("rst_eop",   {31'd0, RxD_endofpacket}, 32'd0);
        check_eq("rst_idle",  {31'd0, RxD_idle}, 32'd0);
        rst_n = 1'b1;

        // Idle rises after 10 bit times of high line; no byte yet, so no end-of-packet.
        hold(1'b1, 8);
        check_eq("idle_early", {31'd0, RxD_idle}, 32'd0);
        hold(1'b1, 4);
        check_eq("idle_after_reset", {31'd0, RxD_idle}, 32'd1);
        check_eq("eop_none_no_byte", n_eop, 0);

        // 1: single byte
        r0 = n_ready; f0 = n_ferr;
        send_frame(8'h41, 1'b1, -1);
        hold(1'b1, 2);
        check_eq("t1_ready_cnt", n_ready - r0, 1);
        check_eq("t1_data", {24'd0, RxD_data}, 32'h41);
        check_eq("t1_ferr_cnt", n_ferr - f0, 0);
        check_eq("t1_idle_low", {31'd0, RxD_idle}, 32'd0);

        // 2: escape byte then data, back-to-back
        r0 = n_ready; q0 = rx_q.size();
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'h55, 1'b1, -1);
        hold(1'b1, 2);
        check_eq("t2_ready_cnt", n_ready - r0, 2);
        if (rx_q.size() >= q0 + 2) begin
            check_eq("t2_byte0", {24'd0, rx_q[q0]}, 32'h00);
            check_eq("t2_byte1", {24'd0, rx_q[q0+1]}, 32'h55);
        end else begin
            check_eq("t2_bytes_logged", rx_q.size() - q0, 2);
        end

        // 3a: 3-tick low pulse is a false start; a following frame still works
        r0 = n_ready; f0 = n_ferr;
        RxD = 1'b0;
        repeat (6) @(negedge clk);
        hold(1'b1, 3);
        check_eq("t3_false_start_ready", n_ready - r0, 0);
        check_eq("t3_false_start_ferr", n_ferr - f0, 0);
        send_frame(8'h5A, 1'b1, -1);
        hold(1'b1, 2);
        check_eq("t3_after_false_start", {24'd0, RxD_data}, 32'h5A);

        // 3b: one-tick glitch in data bit 2 of 0xA5 is voted out
        r0 = n_ready;
        send_frame(8'hA5, 1'b1, 2);
        hold(1'b1, 2);
        check_eq("t3_glitch_ready_cnt", n_ready - r0, 1);
        check_eq("t3_glitch_data", {24'd0, RxD_data}, 32'hA5);

        // 4: framing error then held-low line
        r0 = n_ready; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, -1);
        hold(1'b0, 20);
        check_eq("t4_ferr_cnt", n_ferr - f0, 1);
        check_eq("t4_ready_cnt", n_ready - r0, 0);
        check_eq("t4_data_kept", {24'd0, RxD_data}, 32'hA5);
        hold(1'b1, 2);
        send_frame(8'h66, 1'b1, -1);
        hold(1'b1, 2);
        check_eq("t4_recover_data", {24'd0, RxD_data}, 32'h66);
        check_eq("t4_recover_ready", n_ready - r0, 1);
        check_eq("t4_ferr_once", n_ferr - f0, 1);

        // 5: idle detection and single end-of-packet
        check_eq("t5_no_eop_yet", n_eop, 0);
        e0 = n_eop;
        send_frame(8'h12, 1'b1, -1);
        hold(1'b1, 11);
        check_eq("t5_data", {24'd0, RxD_data}, 32'h12);
        check_eq("t5_idle", {31'd0, RxD_idle}, 32'd1);
        check_eq("t5_eop_once", n_eop - e0, 1);
        hold(1'b1, 20);
        check_eq("t5_no_second_eop", n_eop - e0, 1);
        check_eq("t5_idle_held", {31'd0, RxD_idle}, 32'd1);

        // 6: reset in the middle of 0xFF (after data bit 4)
        r0 = n_ready;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_data",  {24'd0, RxD_data}, 32'h00);
        check_eq("t6_rst_ready", {31'd0, RxD_data_ready}, 32'd0);
        check_eq("t6_rst_ferr",  {31'd0, framing_error}, 32'd0);
        check_eq("t6_rst_eop",   {31'd0, RxD_endofpacket}, 32'd0);
        check_eq("t6_rst_idle",  {31'd0, RxD_idle}, 32'd0);
        RxD = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 2);
        check_eq("t6_partial_dropped", n_ready - r0, 0);
        send_frame(8'h81, 1'b1, -1);
        hold(1'b1, 2);
        check_eq("t6_ready_cnt", n_ready - r0, 1);
        check_eq("t6_data", {24'd0, RxD_data}, 32'h81);

        check_eq("pulse_rules", n_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
